// File: rtl/garbage_pkg.sv
// Shared types, defaults and the saturating counter helper for the garbage scheduler.
package garbage_pkg;

  localparam int unsigned COLS_DEF     = 10;
  localparam int unsigned MAX_PEND_DEF = 15;
  localparam int unsigned LINES_W_DEF  = 3;
  localparam int unsigned PEND_W       = 4;
  localparam int unsigned HOLE_W       = 4;
  localparam int unsigned RND_W        = 5;
  localparam int unsigned SUM_W        = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PICK = 2'd1,
    EMIT = 2'd2
  } state_e;

  // cur + add - dec clipped to ceil; callers guarantee dec is only set when cur != 0
  function automatic logic [PEND_W-1:0] sat_add(input logic [PEND_W-1:0] cur,
                                                input logic [7:0]        add,
                                                input logic              dec,
                                                input logic [PEND_W-1:0] ceil);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(cur) + SUM_W'(add) - SUM_W'(dec);
    if (sum > SUM_W'(ceil)) begin
      return ceil;
    end
    return sum[PEND_W-1:0];
  endfunction

endpackage

// File: rtl/garbage_scheduler_rr_arb2.sv
// Two-way round-robin arbiter; the pointer flips to the other requester after every grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic ptr_q;
  logic ptr_d;

  always_comb begin
    gnt   = 2'b00;
    ptr_d = ptr_q;
    if (en) begin
      if (req == 2'b11) begin
        gnt = ptr_q ? 2'b10 : 2'b01;
      end else begin
        gnt = req;
      end
      if (gnt[0]) begin
        ptr_d = 1'b1;
      end else if (gnt[1]) begin
        ptr_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/garbage_scheduler.sv
// Accumulates garbage-line attacks from two players and hands rows with a random hole to the board.
module garbage_scheduler
  import garbage_pkg::*;
#(
  parameter int unsigned COLS     = COLS_DEF,
  parameter int unsigned MAX_PEND = MAX_PEND_DEF,
  parameter int unsigned LINES_W  = LINES_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [RND_W-1:0]       rnd,
  input  logic [1:0]             atk_valid,
  input  logic [2*LINES_W-1:0]   atk_lines,
  output logic [1:0]             atk_ready,
  input  logic                   clr,
  input  logic                   insert_en,
  output logic                   row_valid,
  output logic [HOLE_W-1:0]      row_hole,
  input  logic                   row_ready,
  output logic [PEND_W-1:0]      pending,
  output logic                   busy
);

  state_e              state_q, state_d;
  logic [PEND_W-1:0]   pending_q, pending_d;
  logic                row_valid_q, row_valid_d;
  logic [HOLE_W-1:0]   row_hole_q, row_hole_d;
  logic                busy_q, busy_d;
  logic [1:0]          gnt;
  logic [LINES_W-1:0]  acc_lines;
  logic                hs;
  logic                dec;

  // Grants are suppressed in reset and while flushing
  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (atk_valid),
    .en    (rst_n & ~clr),
    .gnt   (gnt)
  );

  assign atk_ready = gnt;

  always_comb begin
    acc_lines = '0;
    if (gnt[0]) begin
      acc_lines = atk_lines[LINES_W-1:0];
    end else if (gnt[1]) begin
      acc_lines = atk_lines[2*LINES_W-1:LINES_W];
    end
    hs        = row_valid_q & row_ready;
    dec       = hs & (pending_q != '0);
    pending_d = clr ? '0 : sat_add(pending_q, 8'(acc_lines), dec, PEND_W'(MAX_PEND));
  end

  // Row FSM: PICK rejects out-of-range PRNG values, EMIT holds the row until the board takes it
  always_comb begin
    state_d     = state_q;
    row_valid_d = row_valid_q;
    row_hole_d  = row_hole_q;
    unique case (state_q)
      IDLE: begin
        if (pending_q != '0 && insert_en && !clr) begin
          state_d = PICK;
        end
      end
      PICK: begin
        if (!insert_en || clr) begin
          state_d = IDLE;
        end else if (rnd < RND_W'(COLS)) begin
          row_hole_d  = rnd[HOLE_W-1:0];
          row_valid_d = 1'b1;
          state_d     = EMIT;
        end
      end
      EMIT: begin
        if (hs) begin
          row_valid_d = 1'b0;
          state_d     = (pending_d != '0 && insert_en && !clr) ? PICK : IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        row_valid_d = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      row_valid_q <= 1'b0;
      row_hole_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      row_valid_q <= row_valid_d;
      row_hole_q  <= row_hole_d;
      busy_q      <= busy_d;
    end
  end

  assign row_valid = row_valid_q;
  assign row_hole  = row_hole_q;
  assign pending   = pending_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_garbage_scheduler.sv
// Directed scenarios followed by a randomized run checked against a behavioural model.
module tb_garbage_scheduler;

  localparam int unsigned COLS = 10;
  localparam int unsigned MAXP = 15;
  localparam int unsigned LW   = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [4:0]    rnd = '0;
  logic [1:0]    atk_valid = '0;
  logic [2*LW-1:0] atk_lines = '0;
  logic [1:0]    atk_ready;
  logic          clr = 1'b0;
  logic          insert_en = 1'b0;
  logic          row_valid;
  logic [3:0]    row_hole;
  logic          row_ready = 1'b0;
  logic [3:0]    pending;
  logic          busy;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  garbage_scheduler #(.COLS(COLS), .MAX_PEND(MAXP), .LINES_W(LW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rnd       (rnd),
    .atk_valid (atk_valid),
    .atk_lines (atk_lines),
    .atk_ready (atk_ready),
    .clr       (clr),
    .insert_en (insert_en),
    .row_valid (row_valid),
    .row_hole  (row_hole),
    .row_ready (row_ready),
    .pending   (pending),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; atk_valid = 2'b11; atk_lines = {3'd2, 3'd1};
    clr = 1'b0; insert_en = 1'b0; row_ready = 1'b0; rnd = '0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("reset_ready", 32'(atk_ready), 32'd0);
    end
    rst_n = 1'b1; atk_valid = 2'b00;
    check("reset_pending", 32'(pending), 32'd0);
    check("reset_row_valid", 32'(row_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_hole", 32'(row_hole), 32'd0);
  endtask

  // Model state for the random phase
  int          pend_m, lines_acc, rows_hs, acc, t;
  logic        ptr_m, hs_m, cur_rv;
  logic [1:0]  exp_g;
  logic [3:0]  cur_hole;
  logic [4:0]  cur_rnd;
  logic [4:0]  rej [3] = '{5'd31, 5'd12, 5'd10};
  int          rows;

  initial begin
    // Reset
    do_reset();

    // Single attack of 3 lines, every row takes hole 7
    atk_valid = 2'b01; atk_lines = {3'd0, 3'd3}; insert_en = 1'b1; rnd = 5'd7; row_ready = 1'b1;
    #1 check("single_grant", 32'(atk_ready), 32'd1);
    tick();
    atk_valid = 2'b00;
    check("single_pending_acc", 32'(pending), 32'd3);
    rows = 0;
    for (int c = 0; c < 30 && rows < 3; c++) begin
      if (row_valid) begin
        check("single_hole", 32'(row_hole), 32'd7);
        rows++;
        tick();
        check("single_pending_dec", 32'(pending), 32'(3 - rows));
      end else begin
        tick();
      end
    end
    check("single_rows", 32'(rows), 32'd3);
    tick(); tick();
    check("single_idle_busy", 32'(busy), 32'd0);
    check("single_idle_valid", 32'(row_valid), 32'd0);

    // Contention: grants alternate starting from requester 0
    do_reset();
    atk_valid = 2'b11; atk_lines = {3'd2, 3'd1};
    for (int i = 0; i < 4; i++) begin
      #1 check("contention_grant", 32'(atk_ready), (i % 2 == 0) ? 32'd1 : 32'd2);
      tick();
    end
    atk_valid = 2'b00;
    check("contention_pending", 32'(pending), 32'd6);

    // Saturation
    atk_valid = 2'b01; atk_lines = {3'd0, 3'd7};
    tick();
    check("sat_13", 32'(pending), 32'd13);
    atk_lines = {3'd0, 3'd1};
    tick();
    check("sat_14", 32'(pending), 32'd14);
    atk_lines = {3'd0, 3'd4};
    tick();
    atk_valid = 2'b00;
    check("sat_15", 32'(pending), 32'd15);
    insert_en = 1'b1; rnd = 5'd3;
    for (int c = 0; c < 10 && !row_valid; c++) tick();
    check("sat_row_up", 32'(row_valid), 32'd1);
    check("sat_hole", 32'(row_hole), 32'd3);
    atk_valid = 2'b01; atk_lines = {3'd0, 3'd2}; row_ready = 1'b1;
    #1 check("sat_grant_hs", 32'(atk_ready), 32'd1);
    tick();
    atk_valid = 2'b00; row_ready = 1'b0;
    check("sat_hold_15", 32'(pending), 32'd15);
    check("sat_row_drop", 32'(row_valid), 32'd0);

    // Rejection sampling in PICK
    do_reset();
    atk_valid = 2'b01; atk_lines = {3'd0, 3'd1};
    tick();
    atk_valid = 2'b00;
    check("rej_pending", 32'(pending), 32'd1);
    insert_en = 1'b1; rnd = 5'd31;
    tick();
    check("rej_busy_pick", 32'(busy), 32'd1);
    for (int i = 0; i < 3; i++) begin
      rnd = rej[i];
      tick();
      check("rej_no_row", 32'(row_valid), 32'd0);
      check("rej_busy", 32'(busy), 32'd1);
    end
    rnd = 5'd9;
    tick();
    check("rej_row", 32'(row_valid), 32'd1);
    check("rej_hole", 32'(row_hole), 32'd9);

    // clr during EMIT: row held, pending flushed, no underflow on the late handshake
    atk_valid = 2'b01; atk_lines = {3'd0, 3'd4};
    tick();
    atk_valid = 2'b00;
    check("clr_pending5", 32'(pending), 32'd5);
    clr = 1'b1; atk_valid = 2'b01;
    #1 check("clr_no_grant", 32'(atk_ready), 32'd0);
    tick();
    clr = 1'b0; atk_valid = 2'b00;
    check("clr_pending0", 32'(pending), 32'd0);
    check("clr_row_held", 32'(row_valid), 32'd1);
    check("clr_hole_held", 32'(row_hole), 32'd9);
    row_ready = 1'b1;
    tick();
    row_ready = 1'b0;
    check("clr_no_underflow", 32'(pending), 32'd0);
    check("clr_row_gone", 32'(row_valid), 32'd0);
    check("clr_idle", 32'(busy), 32'd0);

    // insert_en dropping in PICK returns to IDLE keeping the count
    do_reset();
    atk_valid = 2'b01; atk_lines = {3'd0, 3'd2};
    tick();
    atk_valid = 2'b00; insert_en = 1'b1; rnd = 5'd31;
    tick();
    check("ins_pick_busy", 32'(busy), 32'd1);
    insert_en = 1'b0;
    tick();
    check("ins_idle_busy", 32'(busy), 32'd0);
    check("ins_pending", 32'(pending), 32'd2);
    check("ins_no_row", 32'(row_valid), 32'd0);

    // Randomized run against the model
    do_reset();
    pend_m = 0; lines_acc = 0; rows_hs = 0; ptr_m = 1'b0;
    for (int c = 0; c < 800; c++) begin
      atk_valid = 2'($urandom);
      atk_lines = 6'($urandom);
      clr       = ($urandom_range(15) == 0);
      insert_en = ($urandom_range(3) != 0);
      row_ready = 1'($urandom);
      rnd       = 5'($urandom);
      #1;
      if (clr) exp_g = 2'b00;
      else if (atk_valid == 2'b11) exp_g = ptr_m ? 2'b10 : 2'b01;
      else exp_g = atk_valid;
      check("rand_grant", 32'(atk_ready), 32'(exp_g));
      acc = exp_g[0] ? int'(atk_lines[2:0]) : (exp_g[1] ? int'(atk_lines[5:3]) : 0);
      hs_m = row_valid && row_ready;
      cur_rv = row_valid; cur_hole = row_hole; cur_rnd = rnd;
      if (hs_m) rows_hs++;
      if (exp_g != 2'b00) begin
        lines_acc += acc;
        ptr_m = exp_g[0];
      end
      if (clr) pend_m = 0;
      else begin
        t = pend_m + acc - ((hs_m && pend_m != 0) ? 1 : 0);
        pend_m = (t > int'(MAXP)) ? int'(MAXP) : t;
      end
      tick();
      check("rand_pending", 32'(pending), 32'(pend_m));
      if (cur_rv && hs_m) begin
        check("rand_gap", 32'(row_valid), 32'd0);
      end else if (cur_rv) begin
        check("rand_row_hold", 32'(row_valid), 32'd1);
        check("rand_hole_hold", 32'(row_hole), 32'(cur_hole));
      end else if (row_valid) begin
        check("rand_hole_new", 32'(row_hole), 32'(cur_rnd));
        check("rand_hole_range", 32'(row_hole < 4'(COLS)), 32'd1);
      end
    end
    check("rand_rows_le_lines", 32'(rows_hs <= lines_acc), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
